// File: rtl/reg_file_sb_if.sv
// Register file / scoreboard port bundle.
// Read, writeback, issue and hazard signals grouped for the issue stage.
interface reg_file_sb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int NREGS  = 8
);
   logic [ADDR_W-1:0] rd_addr_a;
   logic              rd_use_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic              rd_use_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              issue_en;
   logic [ADDR_W-1:0] issue_dst;
   logic              issue_wr;
   logic              flush;
   logic              stall;
   logic [NREGS-1:0]  pending;

   modport master (
      output rd_addr_a, rd_use_a, rd_addr_b, rd_use_b,
      output wr_en, wr_addr, wr_data,
      output issue_en, issue_dst, issue_wr, flush,
      input  rd_data_a, rd_data_b, stall, pending
   );

   modport slave (
      input  rd_addr_a, rd_use_a, rd_addr_b, rd_use_b,
      input  wr_en, wr_addr, wr_data,
      input  issue_en, issue_dst, issue_wr, flush,
      output rd_data_a, rd_data_b, stall, pending
   );
endinterface

// File: rtl/reg_file_sb.sv
// 8x16 register file with write-through bypass reads
// and a pending-write scoreboard raising RAW/WAW stalls.
module reg_file_sb #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int NREGS  = 8
) (
   input logic          clk,
   input logic          rst_n,
   reg_file_sb_if.slave bus
);

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  pend;
   logic [NREGS-1:0]  pend_nxt;
   logic              byp_a;
   logic              byp_b;
   logic              byp_w;
   logic              haz_a;
   logic              haz_b;
   logic              haz_w;
   logic              stall;
   logic              accept;

   // Writeback into the array; flush never blocks it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.wr_en) begin
         regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
      end else begin
         pend <= pend_nxt;
      end
   end

   // Bypass matches, hazards and read data.
   always_comb begin
      byp_a = bus.wr_en && (bus.wr_addr == bus.rd_addr_a);
      byp_b = bus.wr_en && (bus.wr_addr == bus.rd_addr_b);
      byp_w = bus.wr_en && (bus.wr_addr == bus.issue_dst);
      haz_a = bus.rd_use_a && pend[bus.rd_addr_a] && !byp_a;
      haz_b = bus.rd_use_b && pend[bus.rd_addr_b] && !byp_b;
      haz_w = bus.issue_wr && pend[bus.issue_dst] && !byp_w;
      stall = bus.issue_en && (haz_a || haz_b || haz_w);
      accept = bus.issue_en && !stall;
      bus.rd_data_a = byp_a ? bus.wr_data : regs[bus.rd_addr_a];
      bus.rd_data_b = byp_b ? bus.wr_data : regs[bus.rd_addr_b];
      bus.stall = stall;
      bus.pending = pend;
   end

   // Next pending bits: flush, then new issue, then writeback clear.
   always_comb begin
      pend_nxt = pend;
      if (bus.flush) begin
         pend_nxt = '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (accept && bus.issue_wr &&
                bus.issue_dst == ADDR_W'(i)) begin
               pend_nxt[i] = 1'b1;
            end else if (bus.wr_en &&
                         bus.wr_addr == ADDR_W'(i)) begin
               pend_nxt[i] = 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed hazard scenarios with literal
// expectations, then random traffic against a behavioural model.
module tb_reg_file_sb;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vec = 0;
   int   bad = 0;

   reg_file_sb_if #(.DATA_W(16), .ADDR_W(3), .NREGS(8)) b ();

   reg_file_sb dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b.slave)
   );

   always #5 clk = ~clk;

   logic [15:0] m_regs [8];
   logic [7:0]  m_pend;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h",
                  nm, $time, act, exp);
      end
   endtask

   // Model: reads see the array unless the same-cycle
   // writeback targets the index.
   function automatic logic [15:0] m_read(
      input logic [2:0] a);
      if (b.wr_en && b.wr_addr == a) return b.wr_data;
      return m_regs[a];
   endfunction

   function automatic logic busy(input logic [2:0] a);
      return m_pend[a] && !(b.wr_en && b.wr_addr == a);
   endfunction

   function automatic logic m_stall();
      if (!b.issue_en) return 1'b0;
      return (b.rd_use_a && busy(b.rd_addr_a)) ||
             (b.rd_use_b && busy(b.rd_addr_b)) ||
             (b.issue_wr && busy(b.issue_dst));
   endfunction

   // Compare process: check outputs mid-cycle, then
   // advance the model to the state after the next edge.
   always @(negedge clk) begin
      logic st;
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_regs[i] = '0;
         m_pend = '0;
      end
      st = m_stall();
      chk("rd_data_a", 32'(b.rd_data_a), 32'(m_read(b.rd_addr_a)));
      chk("rd_data_b", 32'(b.rd_data_b), 32'(m_read(b.rd_addr_b)));
      chk("stall", 32'(b.stall), 32'(st));
      chk("pending", 32'(b.pending), 32'(m_pend));
      if (rst_n) begin
         if (b.flush) begin
            m_pend = '0;
         end else begin
            if (b.wr_en) m_pend[b.wr_addr] = 1'b0;
            if (b.issue_en && !st && b.issue_wr)
               m_pend[b.issue_dst] = 1'b1;
         end
         if (b.wr_en) m_regs[b.wr_addr] = b.wr_data;
      end
   end

   task automatic idle();
      b.rd_addr_a = '0; b.rd_use_a = 1'b0;
      b.rd_addr_b = '0; b.rd_use_b = 1'b0;
      b.wr_en = 1'b0; b.wr_addr = '0; b.wr_data = '0;
      b.issue_en = 1'b0; b.issue_dst = '0;
      b.issue_wr = 1'b0; b.flush = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_w(input logic [2:0] d);
      b.issue_en = 1'b1; b.issue_wr = 1'b1; b.issue_dst = d;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_pend = '0;
      idle();
      // Reset state
      #1;
      for (int i = 0; i < 8; i++) begin
         b.rd_addr_a = 3'(i);
         #1;
         chk("rst_rd_a", 32'(b.rd_data_a), 32'h0);
      end
      chk("rst_pend", 32'(b.pending), 32'h0);
      chk("rst_stall", 32'(b.stall), 32'h0);
      step();
      rst_n = 1'b1;
      step();

      // Write then read; same-cycle bypass
      b.wr_en = 1'b1; b.wr_addr = 3'd3; b.wr_data = 16'hBEEF;
      step();
      idle();
      b.rd_addr_a = 3'd3;
      #1 chk("rd_r3", 32'(b.rd_data_a), 32'hBEEF);
      b.wr_en = 1'b1; b.wr_addr = 3'd5; b.wr_data = 16'h1234;
      b.rd_addr_b = 3'd5;
      #1 chk("byp_r5", 32'(b.rd_data_b), 32'h1234);
      step();
      idle();

      // RAW
      issue_w(3'd2);
      #1 chk("raw_acc", 32'(b.stall), 32'h0);
      step();
      idle();
      #1 chk("raw_pend", 32'(b.pending), 32'h04);
      b.issue_en = 1'b1; b.rd_use_a = 1'b1; b.rd_addr_a = 3'd2;
      #1 chk("raw_stall", 32'(b.stall), 32'h1);
      b.wr_en = 1'b1; b.wr_addr = 3'd2; b.wr_data = 16'h5A5A;
      #1 chk("raw_clr", 32'(b.stall), 32'h0);
      chk("raw_byp", 32'(b.rd_data_a), 32'h5A5A);
      step();
      idle();
      #1 chk("raw_done", 32'(b.pending), 32'h00);

      // WAW
      issue_w(3'd6);
      step();
      idle();
      #1 chk("waw_pend", 32'(b.pending), 32'h40);
      issue_w(3'd6);
      #1 chk("waw_stall", 32'(b.stall), 32'h1);
      step();
      #1 chk("waw_hold", 32'(b.pending), 32'h40);
      b.wr_en = 1'b1; b.wr_addr = 3'd6; b.wr_data = 16'h6666;
      #1 chk("waw_acc", 32'(b.stall), 32'h0);
      step();
      idle();
      #1 chk("waw_keep", 32'(b.pending), 32'h40);
      b.wr_en = 1'b1; b.wr_addr = 3'd6; b.wr_data = 16'h6767;
      step();
      idle();
      #1 chk("waw_free", 32'(b.pending), 32'h00);

      // Flush beats a same-cycle accepted issue
      issue_w(3'd2); step();
      issue_w(3'd3); step();
      issue_w(3'd7); step();
      idle();
      #1 chk("fl_pend", 32'(b.pending), 32'h8C);
      issue_w(3'd0);
      b.flush = 1'b1;
      #1 chk("fl_acc", 32'(b.stall), 32'h0);
      step();
      idle();
      #1 chk("fl_clear", 32'(b.pending), 32'h00);

      // Asynchronous reset between edges
      issue_w(3'd0); step();
      issue_w(3'd1); step();
      issue_w(3'd2); step();
      issue_w(3'd3); step();
      idle();
      #1 chk("ar_pend", 32'(b.pending), 32'h0F);
      b.issue_en = 1'b1; b.rd_use_a = 1'b1; b.rd_addr_a = 3'd3;
      #1 chk("ar_pre", 32'(b.stall), 32'h1);
      chk("ar_r3", 32'(b.rd_data_a), 32'hBEEF);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("ar_pend0", 32'(b.pending), 32'h00);
      chk("ar_stall0", 32'(b.stall), 32'h0);
      chk("ar_rd0", 32'(b.rd_data_a), 32'h0);
      step();
      idle();
      step();
      rst_n = 1'b1;
      step();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         b.rd_addr_a = 3'($urandom);
         b.rd_use_a = 1'($urandom);
         b.rd_addr_b = 3'($urandom);
         b.rd_use_b = 1'($urandom);
         b.wr_en = ($urandom_range(0, 2) == 0);
         b.wr_addr = 3'($urandom);
         b.wr_data = 16'($urandom);
         b.issue_en = ($urandom_range(0, 3) != 0);
         b.issue_dst = 3'($urandom);
         b.issue_wr = ($urandom_range(0, 3) != 0);
         b.flush = ($urandom_range(0, 31) == 0);
         rst_n = ($urandom_range(0, 199) != 0);
         step();
      end
      rst_n = 1'b1;
      idle();
      step();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
